commit_unit: RTL and testbench

- In-order commit point for the out-of-order backend.
- Allocates sequence numbers to dispatched instructions and holds completion results until the instruction is oldest.
- Retires at most one instruction per cycle and publishes it as a commit notification (val, seq_num, pc, waddr, wdata, wen).
- This is the publisher side of the CommitNotif interface. Age-comparison subscribers track the oldest in-flight number from its output.

---
 rtl/commit_unit_pkg.sv | 15 +
 rtl/commit_unit_entry_buf.sv | 74 +++++++
 rtl/commit_unit.sv | 123 ++++++++++++
 tb/tb_commit_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_unit_pkg.sv
// Shared types and constants for the in-order commit unit and its entry buffer.
package commit_unit_pkg;

  localparam int unsigned seq_num_bits = 5;
  localparam int unsigned depth        = 1 << seq_num_bits;

  typedef struct packed {
    logic        complete;
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
  } commit_entry_t;

endpackage

// File: rtl/commit_unit_entry_buf.sv
// Entry storage for the commit unit: alloc/complete flags plus completion payload,
// one completion write port and one read port at the head of the window.
module commit_unit_entry_buf
  import commit_unit_pkg::*;
#(
  parameter  int unsigned p_seq_num_bits = seq_num_bits,
  localparam int unsigned l_depth        = 1 << p_seq_num_bits
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_en,
  input  logic [p_seq_num_bits-1:0] alloc_idx,
  input  logic                      dealloc_en,
  input  logic [p_seq_num_bits-1:0] dealloc_idx,
  input  logic [l_depth-1:0]        kill_mask,
  input  logic                      complete_val,
  input  logic [p_seq_num_bits-1:0] complete_idx,
  input  logic [31:0]               complete_pc,
  input  logic [4:0]                complete_waddr,
  input  logic [31:0]               complete_wdata,
  input  logic                      complete_wen,
  input  logic [p_seq_num_bits-1:0] head_idx,
  output commit_entry_t             head_entry
);

  logic [l_depth-1:0] alloc_q;
  logic [l_depth-1:0] complete_q;
  logic [l_depth-1:0] alloc_oh;
  logic [l_depth-1:0] dealloc_oh;
  logic [l_depth-1:0] complete_oh;
  logic               complete_ok;

  logic [31:0] pc_q    [l_depth];
  logic [4:0]  waddr_q [l_depth];
  logic [31:0] wdata_q [l_depth];
  logic        wen_q   [l_depth];

  // Completions aimed at entries that were never allocated are dropped.
  assign complete_ok = complete_val && alloc_q[complete_idx];

  always_comb begin
    alloc_oh    = alloc_en   ? (l_depth'(1) << alloc_idx)    : '0;
    dealloc_oh  = dealloc_en ? (l_depth'(1) << dealloc_idx)  : '0;
    complete_oh = complete_ok ? (l_depth'(1) << complete_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q    <= '0;
      complete_q <= '0;
    end else begin
      alloc_q    <= (alloc_q | alloc_oh) & ~dealloc_oh & ~kill_mask;
      complete_q <= (complete_q | complete_oh) & ~alloc_oh & ~dealloc_oh & ~kill_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (complete_ok) begin
      pc_q[complete_idx]    <= complete_pc;
      waddr_q[complete_idx] <= complete_waddr;
      wdata_q[complete_idx] <= complete_wdata;
      wen_q[complete_idx]   <= complete_wen;
    end
  end

  always_comb begin
    head_entry.complete = complete_q[head_idx];
    head_entry.pc       = pc_q[head_idx];
    head_entry.waddr    = waddr_q[head_idx];
    head_entry.wdata    = wdata_q[head_idx];
    head_entry.wen      = wen_q[head_idx];
  end

endmodule

// File: rtl/commit_unit.sv
// In-order commit point: grants sequence numbers, buffers completions, retires one per cycle.
// Optional squash support is enabled with COMMIT_UNIT_SQUASH_EN.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int unsigned p_seq_num_bits = seq_num_bits
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_val,
  output logic                      alloc_rdy,
  output logic [p_seq_num_bits-1:0] alloc_seq_num,
  input  logic                      complete_val,
  input  logic [p_seq_num_bits-1:0] complete_seq_num,
  input  logic [31:0]               complete_pc,
  input  logic [4:0]                complete_waddr,
  input  logic [31:0]               complete_wdata,
  input  logic                      complete_wen,
`ifdef COMMIT_UNIT_SQUASH_EN
  input  logic                      squash_val,
  input  logic [p_seq_num_bits-1:0] squash_seq_num,
`endif
  output logic                      commit_val,
  output logic [p_seq_num_bits-1:0] commit_seq_num,
  output logic [31:0]               commit_pc,
  output logic [4:0]                commit_waddr,
  output logic [31:0]               commit_wdata,
  output logic                      commit_wen
);

  localparam int unsigned l_depth = 1 << p_seq_num_bits;
  localparam logic [p_seq_num_bits:0] l_full = (p_seq_num_bits + 1)'(l_depth);

  logic [p_seq_num_bits-1:0] head_q, tail_q, head_nxt, tail_nxt;
  logic [p_seq_num_bits:0]   count_q, count_nxt;
  logic [l_depth-1:0]        kill_mask;
  logic                      alloc_fire;
  commit_entry_t             head_entry;

`ifdef COMMIT_UNIT_SQUASH_EN
  logic [p_seq_num_bits-1:0] sq_off, ent_off, sq_span;

  // Age is measured as distance from head, so anything further than the survivor dies.
  always_comb begin
    sq_off    = squash_seq_num - head_q;
    ent_off   = '0;
    kill_mask = '0;
    for (int i = 0; i < l_depth; i++) begin
      ent_off = p_seq_num_bits'(i) - head_q;
      if (squash_val && (ent_off > sq_off)) kill_mask[i] = 1'b1;
    end
  end

  assign alloc_rdy = (count_q != l_full) && !squash_val;
`else
  assign kill_mask = '0;
  assign alloc_rdy = (count_q != l_full);
`endif

  assign alloc_seq_num = tail_q;
  assign alloc_fire    = alloc_val && alloc_rdy;

  assign commit_val     = (count_q != '0) && head_entry.complete;
  assign commit_seq_num = head_q;
  assign commit_pc      = commit_val ? head_entry.pc    : '0;
  assign commit_waddr   = commit_val ? head_entry.waddr : '0;
  assign commit_wdata   = commit_val ? head_entry.wdata : '0;
  assign commit_wen     = commit_val && head_entry.wen;

  always_comb begin
    head_nxt  = commit_val ? head_q + p_seq_num_bits'(1) : head_q;
    tail_nxt  = alloc_fire ? tail_q + p_seq_num_bits'(1) : tail_q;
    count_nxt = count_q;
    case ({alloc_fire, commit_val})
      2'b10:   count_nxt = count_q + (p_seq_num_bits + 1)'(1);
      2'b01:   count_nxt = count_q - (p_seq_num_bits + 1)'(1);
      default: count_nxt = count_q;
    endcase
`ifdef COMMIT_UNIT_SQUASH_EN
    sq_span = '0;
    // The survivor is allocated, so a zero span after squash means a full window.
    if (squash_val) begin
      tail_nxt  = squash_seq_num + p_seq_num_bits'(1);
      sq_span   = tail_nxt - head_q;
      count_nxt = ((sq_span == '0) ? l_full : {1'b0, sq_span})
                  - (p_seq_num_bits + 1)'(commit_val);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_nxt;
      tail_q  <= tail_nxt;
      count_q <= count_nxt;
    end
  end

  commit_unit_entry_buf #(
    .p_seq_num_bits (p_seq_num_bits)
  ) entry_buf (
    .clk            (clk),
    .rst            (rst),
    .alloc_en       (alloc_fire),
    .alloc_idx      (tail_q),
    .dealloc_en     (commit_val),
    .dealloc_idx    (head_q),
    .kill_mask      (kill_mask),
    .complete_val   (complete_val),
    .complete_idx   (complete_seq_num),
    .complete_pc    (complete_pc),
    .complete_waddr (complete_waddr),
    .complete_wdata (complete_wdata),
    .complete_wen   (complete_wen),
    .head_idx       (head_q),
    .head_entry     (head_entry)
  );

endmodule

// File: tb/tb_commit_unit.sv
// Testbench for commit_unit: directed scenarios plus random traffic against a queue-based model.
// Squash scenarios are included when COMMIT_UNIT_SQUASH_EN is defined.
module tb_commit_unit;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_val;
  logic        alloc_rdy;
  logic [4:0]  alloc_seq_num;
  logic        complete_val;
  logic [4:0]  complete_seq_num;
  logic [31:0] complete_pc;
  logic [4:0]  complete_waddr;
  logic [31:0] complete_wdata;
  logic        complete_wen;
  logic        commit_val;
  logic [4:0]  commit_seq_num;
  logic [31:0] commit_pc;
  logic [4:0]  commit_waddr;
  logic [31:0] commit_wdata;
  logic        commit_wen;
`ifdef COMMIT_UNIT_SQUASH_EN
  logic        squash_val;
  logic [4:0]  squash_seq_num;
`endif

  always #5 clk = ~clk;

  commit_unit #(.p_seq_num_bits(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_val        (alloc_val),
    .alloc_rdy        (alloc_rdy),
    .alloc_seq_num    (alloc_seq_num),
    .complete_val     (complete_val),
    .complete_seq_num (complete_seq_num),
    .complete_pc      (complete_pc),
    .complete_waddr   (complete_waddr),
    .complete_wdata   (complete_wdata),
    .complete_wen     (complete_wen),
`ifdef COMMIT_UNIT_SQUASH_EN
    .squash_val       (squash_val),
    .squash_seq_num   (squash_seq_num),
`endif
    .commit_val       (commit_val),
    .commit_seq_num   (commit_seq_num),
    .commit_pc        (commit_pc),
    .commit_waddr     (commit_waddr),
    .commit_wdata     (commit_wdata),
    .commit_wen       (commit_wen)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: in-flight sequence numbers in age order plus per-number state.
  int          inflight[$];
  bit          m_alloc [DEPTH];
  bit          m_done  [DEPTH];
  logic [31:0] m_pc    [DEPTH];
  logic [4:0]  m_waddr [DEPTH];
  logic [31:0] m_wdata [DEPTH];
  bit          m_wen   [DEPTH];
  int          m_next;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    inflight.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_alloc[i] = 1'b0;
      m_done[i]  = 1'b0;
    end
    m_next = 0;
  endtask

  task automatic doReset();
    rst          = 1'b1;
    alloc_val    = 1'b0;
    complete_val = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, then advance the model past the edge.
  task automatic applyStimulus(input bit av, input bit cv, input logic [4:0] cs,
                               input logic [31:0] pc, input logic [4:0] wa,
                               input logic [31:0] wd, input bit we);
    bit exp_rdy;
    bit exp_commit;
    bit sq;
    int hd;
    alloc_val        = av;
    complete_val     = cv;
    complete_seq_num = cs;
    complete_pc      = pc;
    complete_waddr   = wa;
    complete_wdata   = wd;
    complete_wen     = we;
    sq = 1'b0;
`ifdef COMMIT_UNIT_SQUASH_EN
    sq = squash_val;
`endif
    #4;
    exp_rdy    = (inflight.size() < DEPTH) && !sq;
    exp_commit = (inflight.size() > 0) && m_done[inflight[0]];
    checkOutput("alloc_rdy", 32'(alloc_rdy), 32'(exp_rdy));
    checkOutput("alloc_seq_num", 32'(alloc_seq_num), 32'(m_next));
    checkOutput("commit_val", 32'(commit_val), 32'(exp_commit));
    if (exp_commit) begin
      hd = inflight[0];
      checkOutput("commit_seq_num", 32'(commit_seq_num), 32'(hd));
      checkOutput("commit_pc", commit_pc, m_pc[hd]);
      checkOutput("commit_waddr", 32'(commit_waddr), 32'(m_waddr[hd]));
      checkOutput("commit_wdata", commit_wdata, m_wdata[hd]);
      checkOutput("commit_wen", 32'(commit_wen), 32'(m_wen[hd]));
    end
    if (cv && m_alloc[cs]) begin
      m_done[cs]  = 1'b1;
      m_pc[cs]    = pc;
      m_waddr[cs] = wa;
      m_wdata[cs] = wd;
      m_wen[cs]   = we;
    end
`ifdef COMMIT_UNIT_SQUASH_EN
    if (sq) begin
      while (inflight.size() > 0 && inflight[inflight.size()-1] != int'(squash_seq_num)) begin
        m_alloc[inflight[inflight.size()-1]] = 1'b0;
        m_done[inflight[inflight.size()-1]]  = 1'b0;
        void'(inflight.pop_back());
      end
      m_next = (int'(squash_seq_num) + 1) % DEPTH;
    end
`endif
    if (exp_commit) begin
      m_alloc[inflight[0]] = 1'b0;
      m_done[inflight[0]]  = 1'b0;
      void'(inflight.pop_front());
    end
    if (av && exp_rdy) begin
      inflight.push_back(m_next);
      m_alloc[m_next] = 1'b1;
      m_done[m_next]  = 1'b0;
      m_next = (m_next + 1) % DEPTH;
    end
    @(posedge clk); #1;
    alloc_val    = 1'b0;
    complete_val = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic allocOne();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic completeSeq(input logic [4:0] s);
    applyStimulus(1'b0, 1'b1, s, 32'h1000 + 32'(s) * 4, 5'($urandom), $urandom, 1'($urandom));
  endtask

  initial begin
    rst              = 1'b1;
    alloc_val        = 1'b0;
    complete_val     = 1'b0;
    complete_seq_num = '0;
    complete_pc      = '0;
    complete_waddr   = '0;
    complete_wdata   = '0;
    complete_wen     = 1'b0;
`ifdef COMMIT_UNIT_SQUASH_EN
    squash_val       = 1'b0;
    squash_seq_num   = '0;
`endif
    @(posedge clk); #1;
    doReset();

    checkOutput("reset_alloc_rdy", 32'(alloc_rdy), 32'd1);
    checkOutput("reset_alloc_seq_num", 32'(alloc_seq_num), 32'd0);
    checkOutput("reset_commit_val", 32'(commit_val), 32'd0);
    checkOutput("reset_commit_seq_num", 32'(commit_seq_num), 32'd0);
    checkOutput("reset_commit_pc", commit_pc, 32'd0);
    checkOutput("reset_commit_wdata", commit_wdata, 32'd0);

    // Out-of-order completion retires in order.
    repeat (3) allocOne();
    completeSeq(5'd2);
    completeSeq(5'd1);
    completeSeq(5'd0);
    idle(4);

    // Fill to full, then free one entry and observe wrap of the grant.
    doReset();
    repeat (33) allocOne();
    completeSeq(5'd0);
    repeat (3) allocOne();
    completeSeq(5'd1);
    idle(2);

    // Walk head to 30, then retire across the wrap.
    doReset();
    for (int i = 0; i < 30; i++) begin
      allocOne();
      completeSeq(5'(i));
    end
    idle(1);
    repeat (4) allocOne();
    completeSeq(5'd1);
    completeSeq(5'd0);
    completeSeq(5'd31);
    completeSeq(5'd30);
    idle(5);

    // Completion to an unallocated entry is ignored.
    doReset();
    completeSeq(5'd7);
    idle(2);
    allocOne();
    idle(2);

    // Reset with work in flight discards everything.
    doReset();
    repeat (5) allocOne();
    completeSeq(5'd1);
    completeSeq(5'd3);
    doReset();
    checkOutput("midreset_commit_val", 32'(commit_val), 32'd0);
    checkOutput("midreset_alloc_seq_num", 32'(alloc_seq_num), 32'd0);
    checkOutput("midreset_alloc_rdy", 32'(alloc_rdy), 32'd1);
    completeSeq(5'd0);
    allocOne();
    idle(2);

`ifdef COMMIT_UNIT_SQUASH_EN
    doReset();
    repeat (6) allocOne();
    squash_val     = 1'b1;
    squash_seq_num = 5'd2;
    allocOne();
    squash_val = 1'b0;
    idle(1);
    completeSeq(5'd4);
    completeSeq(5'd0);
    completeSeq(5'd1);
    completeSeq(5'd2);
    idle(4);
`endif

    // Random traffic with phases of different allocation pressure.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      bit          av;
      bit          cv;
      logic [4:0]  cs;
      int          pct;
      pct = ((c / 300) % 2 == 0) ? 85 : 30;
      av  = ($urandom_range(0, 99) < pct);
      cv  = ($urandom_range(0, 99) < 60);
      if (inflight.size() > 0 && $urandom_range(0, 99) < 85)
        cs = 5'(inflight[$urandom_range(0, inflight.size() - 1)]);
      else
        cs = 5'($urandom_range(0, DEPTH - 1));
      if (c == 1500) doReset();
      applyStimulus(av, cv, cs, $urandom, 5'($urandom), $urandom, 1'($urandom));
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
